// File: rtl/frame_serializer_pkg.sv
// Shared definitions for the frame serializer family: FSM state encoding,
// lead-in counter width and the frame length derivation.
// Build option: FRAME_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package frame_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEAD  = 2'b01,
        SHIFT = 2'b10
    } state_e;

    // Lead-in counter covers LEAD_CYCLES up to 255.
    localparam int LEAD_CNT_W = 8;

`ifdef FRAME_SERIALIZER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of serial bits per frame for a given parallel word width.
    function automatic int frame_bits(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/frame_serializer_sync_edge_detect.sv
// Rising-edge detector for a strobe already synchronous to the clock.
// The history flop resets to 1 so a strobe that is high when reset is
// released is not mistaken for a fresh edge.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic rise_o
);

    logic sync_q;

    // Remember last cycle's strobe level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= sync_i;
        end
    end

    assign rise_o = sync_i & ~sync_q;

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial frame serializer with a one-word holding register.
// A rising edge of frame_sync starts a frame: optional lead-in, then
// FRAME_BITS contiguous bits on ser_out framed by ser_frame.
// Build option: FRAME_SERIALIZER_PARITY_EN adds a trailing even-parity bit.
module frame_serializer
    import frame_ser_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int MSB_FIRST   = 0,
    parameter int LEAD_CYCLES = 0
) (
    input  logic             fast_clock,
    input  logic             reset,
    input  logic             frame_sync,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             frame_done,
    output logic             underrun,
    output logic             sync_err
);

    localparam int FRAME_BITS = frame_bits(WIDTH);
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);
    localparam logic [LEAD_CNT_W-1:0] LEAD_LAST =
        LEAD_CNT_W'((LEAD_CYCLES > 0) ? (LEAD_CYCLES - 1) : 0);

    state_e                  state_q, state_d;
    logic [LEAD_CNT_W-1:0]   lead_cnt_q, lead_cnt_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]        shreg_q, shreg_d;
    logic [WIDTH-1:0]        hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    loaded_full_q, loaded_full_d;
    logic                    ser_out_q, ser_out_d;
    logic                    ser_frame_q, ser_frame_d;
    logic                    frame_done_q, frame_done_d;
    logic                    underrun_q, underrun_d;
    logic                    sync_err_q, sync_err_d;
`ifdef FRAME_SERIALIZER_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic                    sync_rise;
    logic                    load_now;
    logic [WIDTH-1:0]        load_word;

    // Bit that leaves the word first in the configured order.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its leading bit consumed.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    sync_edge_detect u_sync_edge (
        .clk_i  (fast_clock),
        .rst_ni (reset),
        .sync_i (frame_sync),
        .rise_o (sync_rise)
    );

    // An empty holding register loads zeros and flags an underrun.
    assign load_word  = hold_full_q ? hold_q : '0;
    assign data_ready = ~hold_full_q;

    // Next-state logic: frame sequencing, serial output and holding register.
    always_comb begin
        state_d       = state_q;
        lead_cnt_d    = lead_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        loaded_full_d = 1'b0;
        ser_out_d     = 1'b0;
        ser_frame_d   = 1'b0;
        frame_done_d  = 1'b0;
        underrun_d    = 1'b0;
        sync_err_d    = sync_rise & (state_q != IDLE);
`ifdef FRAME_SERIALIZER_PARITY_EN
        parity_d      = parity_q;
`endif
        load_now      = 1'b0;

        case (state_q)
            IDLE: begin
                if (sync_rise) begin
                    if (LEAD_CYCLES > 0) begin
                        state_d    = LEAD;
                        lead_cnt_d = '0;
                    end else begin
                        load_now = 1'b1;
                    end
                end
            end
            LEAD: begin
                if (lead_cnt_q == LEAD_LAST) begin
                    load_now = 1'b1;
                end else begin
                    lead_cnt_d = lead_cnt_q + LEAD_CNT_W'(1);
                end
            end
            SHIFT: begin
                if (bit_cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    ser_frame_d  = 1'b1;
                    bit_cnt_d    = bit_cnt_q + CNT_W'(1);
                    frame_done_d = ((bit_cnt_q + CNT_W'(1)) == CNT_LAST);
`ifdef FRAME_SERIALIZER_PARITY_EN
                    if (bit_cnt_q == CNT_W'(WIDTH)) begin
                        ser_out_d = parity_q;
                    end else begin
                        ser_out_d = lead_bit(shreg_q);
                        shreg_d   = advance(shreg_q);
                    end
`else
                    ser_out_d = lead_bit(shreg_q);
                    shreg_d   = advance(shreg_q);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The first bit is driven straight from the word being loaded so it
        // appears the cycle right after the load decision.
        if (load_now) begin
            state_d       = SHIFT;
            shreg_d       = advance(load_word);
            ser_out_d     = lead_bit(load_word);
            ser_frame_d   = 1'b1;
            bit_cnt_d     = CNT_W'(1);
            underrun_d    = ~hold_full_q;
            loaded_full_d = hold_full_q;
`ifdef FRAME_SERIALIZER_PARITY_EN
            parity_d      = ^load_word;
`endif
        end

        // A word accepted in the load cycle was not used and stays for the next frame.
        if (data_valid && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end else if (loaded_full_q) begin
            hold_full_d = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge fast_clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            lead_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            loaded_full_q <= 1'b0;
            ser_out_q     <= 1'b0;
            ser_frame_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            lead_cnt_q    <= lead_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            loaded_full_q <= loaded_full_d;
            ser_out_q     <= ser_out_d;
            ser_frame_q   <= ser_frame_d;
            frame_done_q  <= frame_done_d;
            underrun_q    <= underrun_d;
            sync_err_q    <= sync_err_d;
`ifdef FRAME_SERIALIZER_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_frame  = ser_frame_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: instance 0 is LSB-first with no lead-in,
// instance 1 is MSB-first with a 71-cycle lead-in. Expected frames are queued
// when a sync edge is driven and compared when the serial frame completes.
`timescale 1ns/1ps
module tb_frame_serializer;

    localparam int W     = 16;
    localparam int LEAD1 = 71;
`ifdef FRAME_SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    typedef struct {
        logic [W-1:0] word;
        int           start;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         fs   [2];
    logic [W-1:0] din  [2];
    logic         dv   [2];
    logic         rdy  [2];
    logic         so   [2];
    logic         sf   [2];
    logic         fd   [2];
    logic         ur   [2];
    logic         se   [2];

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t q0[$];
    exp_t q1[$];

    frame_serializer #(.WIDTH(W), .MSB_FIRST(0), .LEAD_CYCLES(0)) u_dut0 (
        .fast_clock (clk),
        .reset      (rst_n),
        .frame_sync (fs[0]),
        .data_in    (din[0]),
        .data_valid (dv[0]),
        .data_ready (rdy[0]),
        .ser_out    (so[0]),
        .ser_frame  (sf[0]),
        .frame_done (fd[0]),
        .underrun   (ur[0]),
        .sync_err   (se[0])
    );

    frame_serializer #(.WIDTH(W), .MSB_FIRST(1), .LEAD_CYCLES(LEAD1)) u_dut1 (
        .fast_clock (clk),
        .reset      (rst_n),
        .frame_sync (fs[1]),
        .data_in    (din[1]),
        .data_valid (dv[1]),
        .data_ready (rdy[1]),
        .ser_out    (so[1]),
        .ser_frame  (sf[1]),
        .frame_done (fd[1]),
        .underrun   (ur[1]),
        .sync_err   (se[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int d, input logic [W-1:0] w, input int start);
        exp_t e;
        e.word  = w;
        e.start = start;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Serial frame capture and scoreboard compare.
    int           nbits [2];
    int           st    [2];
    logic [W-1:0] acc   [2];
    logic         par   [2];

    task automatic frame_end(input int d);
        exp_t e;
        int   have;
        have = (d == 0) ? q0.size() : q1.size();
        check($sformatf("frame_expected%0d", d), (have > 0), 1);
        if (have > 0) begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("frame_word%0d", d), acc[d], e.word);
            check($sformatf("frame_start%0d", d), st[d], e.start);
            check($sformatf("frame_len%0d", d), nbits[d], NB);
`ifdef FRAME_SERIALIZER_PARITY_EN
            check($sformatf("parity_bit%0d", d), par[d], ^e.word);
`endif
        end
    endtask

    initial begin
        nbits[0] = 0;
        nbits[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    nbits[d] = 0;
                end else if (sf[d]) begin
                    if (nbits[d] == 0) st[d] = cyc;
                    if (nbits[d] < W) begin
                        if (d == 1) acc[d][W-1-nbits[d]] = so[d];
                        else        acc[d][nbits[d]]     = so[d];
                    end else begin
                        par[d] = so[d];
                    end
                    nbits[d] = nbits[d] + 1;
                    if (fd[d]) begin
                        frame_end(d);
                        nbits[d] = 0;
                    end
                end else if (nbits[d] != 0) begin
                    check($sformatf("frame_done_seen%0d", d), nbits[d], 0);
                    nbits[d] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic load(input int d, input logic [W-1:0] w);
        check($sformatf("ready_before_load%0d", d), rdy[d], 1);
        din[d] = w;
        dv[d]  = 1'b1;
        tick();
        dv[d]  = 1'b0;
    endtask

    int E;
    int hi_cnt;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            fs[d]  = 1'b0;
            din[d] = '0;
            dv[d]  = 1'b0;
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ser_out%0d", d), so[d], 0);
            check($sformatf("rst_ser_frame%0d", d), sf[d], 0);
            check($sformatf("rst_frame_done%0d", d), fd[d], 0);
            check($sformatf("rst_underrun%0d", d), ur[d], 0);
            check($sformatf("rst_sync_err%0d", d), se[d], 0);
            check($sformatf("rst_ready%0d", d), rdy[d], 1);
        end
        rst_n = 1'b1;
        tick();

        // Basic frame, then a back-to-back frame in the first IDLE cycle.
        load(0, 16'hA5C3);
        check("ready_full", rdy[0], 0);
        fs[0] = 1'b1;
        E = cyc;
        push(0, 16'hA5C3, E + 1);
        tick();
        fs[0] = 1'b0;
        check("t1_first_bit", so[0], 1);
        check("t1_frame_on", sf[0], 1);
        check("t1_underrun", ur[0], 0);
        check("t1_sync_err", se[0], 0);
        check("t1_ready_e1", rdy[0], 0);
        tick();
        check("t1_ready_e2", rdy[0], 1);
        load(0, 16'h5A5A);
        tick_to(E + NB);
        check("t1_done_last", fd[0], 1);
        check("t1_frame_last", sf[0], 1);
        tick();
        check("t1_frame_off", sf[0], 0);
        check("t1_ser_out_idle", so[0], 0);
        check("t1_done_off", fd[0], 0);
        fs[0] = 1'b1;
        E = cyc;
        push(0, 16'h5A5A, E + 1);
        tick();
        fs[0] = 1'b0;
        check("t1b_frame_on", sf[0], 1);
        tick_to(E + NB + 2);

        // Underrun: no word held.
        check("t2_ready", rdy[0], 1);
        fs[0] = 1'b1;
        E = cyc;
        push(0, '0, E + 1);
        tick();
        fs[0] = 1'b0;
        check("t2_underrun_e1", ur[0], 1);
        check("t2_ready_e1", rdy[0], 1);
        tick();
        check("t2_underrun_e2", ur[0], 0);
        check("t2_ready_e2", rdy[0], 1);
        tick_to(E + NB + 2);

        // Second edge during SHIFT.
        load(0, 16'h1234);
        fs[0] = 1'b1;
        E = cyc;
        push(0, 16'h1234, E + 1);
        tick();
        fs[0] = 1'b0;
        tick_to(E + 8);
        fs[0] = 1'b1;
        tick();
        fs[0] = 1'b0;
        check("t3_sync_err", se[0], 1);
        tick();
        check("t3_sync_err_off", se[0], 0);
        tick_to(E + NB + 1);
        check("t3_frame_off", sf[0], 0);
        tick_to(E + NB + 4);
        check("t3_no_restart", sf[0], 0);

        // Word offered in the load cycle of an underrun frame is kept.
        fs[0]  = 1'b1;
        din[0] = 16'hBEEF;
        dv[0]  = 1'b1;
        E = cyc;
        push(0, '0, E + 1);
        tick();
        dv[0] = 1'b0;
        fs[0] = 1'b0;
        check("t4_underrun", ur[0], 1);
        check("t4_word_held", rdy[0], 0);
        tick_to(E + NB + 2);
        fs[0] = 1'b1;
        E = cyc;
        push(0, 16'hBEEF, E + 1);
        tick();
        fs[0] = 1'b0;
        check("t4b_underrun", ur[0], 0);
        tick_to(E + NB + 2);

        // Reset mid-frame with frame_sync held high.
        load(0, 16'hFFFF);
        fs[0] = 1'b1;
        E = cyc;
        push(0, 16'hFFFF, E + 1);
        tick_to(E + 5);
        check("t5_bit5", so[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ser_out", so[0], 0);
        check("t5_rst_ser_frame", sf[0], 0);
        check("t5_rst_ready", rdy[0], 1);
        q0.delete();
        tick();
        rst_n = 1'b1;
        hi_cnt = 0;
        repeat (6) begin
            tick();
            if (sf[0]) hi_cnt = hi_cnt + 1;
        end
        check("t5_no_frame_after_reset", hi_cnt, 0);
        fs[0] = 1'b0;
        tick();
        load(0, 16'h0007);
        fs[0] = 1'b1;
        E = cyc;
        push(0, 16'h0007, E + 1);
        tick();
        fs[0] = 1'b0;
        check("t5_new_frame", sf[0], 1);
        tick_to(E + NB + 2);

        // MSB-first instance with lead-in; word arrives during LEAD.
        check("t6_ready", rdy[1], 1);
        fs[1] = 1'b1;
        E = cyc;
        push(1, 16'h8000, E + 1 + LEAD1);
        tick();
        fs[1] = 1'b0;
        check("t6_no_frame_in_lead", sf[1], 0);
        tick_to(E + 30);
        din[1] = 16'h8000;
        dv[1]  = 1'b1;
        tick();
        dv[1]  = 1'b0;
        check("t6_ready_full", rdy[1], 0);
        tick_to(E + 40);
        fs[1] = 1'b1;
        tick();
        fs[1] = 1'b0;
        check("t6_sync_err_lead", se[1], 1);
        tick_to(E + LEAD1);
        check("t6_frame_before", sf[1], 0);
        tick();
        check("t6_first_bit", so[1], 1);
        check("t6_frame_on", sf[1], 1);
        check("t6_underrun", ur[1], 0);
        check("t6_ready_e72", rdy[1], 0);
        tick();
        check("t6_second_bit", so[1], 0);
        check("t6_ready_e73", rdy[1], 1);
        tick_to(E + 1 + LEAD1 + NB + 2);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
